// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store.
// Optional build macro ARB_STARVE_GUARD_EN bounds how long data traffic may starve a fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;

  state_t            state;
  logic [2:0]        lat;
  logic              kill;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              fetch_ok;
  logic              fetch_first;
  logic              grant_d;
  logic              grant_f;
  logic              done;

  assign fetch_ok = if_req & ~if_cancel;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve;

  assign fetch_first = fetch_ok && (starve >= 4'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (grant_f || !if_req) begin
      starve <= '0;
    end else if (grant_d && (starve != 4'hF)) begin
      starve <= starve + 4'd1;
    end
  end
`else
  logic unused_starve_max;

  assign fetch_first       = 1'b0;
  assign unused_starve_max = (STARVE_MAX == 0);
`endif

  assign done    = (state != IDLE) && (lat == 3'd0);
  assign grant_d = rst_n && (state == IDLE) && d_req && !fetch_first;
  assign grant_f = rst_n && (state == IDLE) && fetch_ok && (!d_req || fetch_first);

  // Command fields are zeroed whenever no access is granted this cycle.
  assign m_en    = grant_d | grant_f;
  assign m_we    = grant_d & d_we;
  assign m_addr  = grant_d ? d_addr : (grant_f ? if_addr : '0);
  assign m_wdata = grant_d ? d_wdata : '0;
  assign m_be    = grant_d ? d_be : (grant_f ? 4'hF : 4'h0);

  assign if_valid  = rst_n && done && (state == RD_IF) && !kill && !if_cancel;
  assign d_valid   = (grant_d && d_we) || (rst_n && done && (state == RD_D));
  assign if_rdata  = !rst_n ? '0 : (if_valid ? m_rdata : if_rdata_q);
  assign d_rdata   = !rst_n ? '0 : ((done && (state == RD_D)) ? m_rdata : d_rdata_q);
  assign stall_if  = rst_n & if_req & ~if_valid & ~if_cancel;
  assign stall_mem = rst_n & d_req & ~d_valid;

  // A killed fetch still runs to completion; it only loses its valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat        <= '0;
      kill       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_valid) if_rdata_q <= m_rdata;
      if (done && (state == RD_D)) d_rdata_q <= m_rdata;
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_d && !d_we) begin
            state <= RD_D;
            lat   <= 3'(MEM_LAT - 1);
          end else if (grant_f) begin
            state <= RD_IF;
            lat   <= 3'(MEM_LAT - 1);
          end
        end
        RD_IF, RD_D: begin
          if ((state == RD_IF) && if_cancel) kill <= 1'b1;
          if (lat == 3'd0) begin
            state <= IDLE;
            kill  <= 1'b0;
          end else begin
            lat <= lat - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written sequences for
// starvation and mid-read reset; a small latency-line memory model feeds m_rdata.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;
  localparam logic [31:0] I1 = 32'h00500093;
  localparam logic [31:0] I2 = 32'hA5000020;
  localparam logic [31:0] I3 = 32'hA5000040;
  localparam logic [31:0] I4 = 32'hA5000070;
  localparam logic [31:0] D1 = 32'h11223344;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_cancel, d_req, d_we;
  logic [8:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, m_wdata, m_rdata;
  logic        if_valid, d_valid, stall_if, stall_mem, m_en, m_we;
  logic [8:0]  m_addr;
  logic [3:0]  m_be;

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic ifr; logic [8:0] ia; logic ic; logic dr; logic dw; logic [8:0] da;
    logic [31:0] dwd; logic [3:0] be;
    logic men; logic mwe; logic [8:0] ma; logic [3:0] mbe; logic [31:0] mwd;
    logic ifv; logic [31:0] ird; logic dv; logic [31:0] drd; logic sif; logic smem;
  } vec_t;

  vec_t vecs [30];

  logic [31:0] mem [0:511];
  logic [31:0] rd_pipe [0:7];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(9), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata)
  );

  // Memory model: read data appears MEM_LAT cycles after the issuing cycle.
  always @(posedge clk) begin
    rd_pipe[0] <= (m_en && !m_we) ? mem[m_addr] : 32'hBAD0BAD0;
    for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_rdata = rd_pipe[MEM_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req    = v.ifr;
    if_addr   = v.ia;
    if_cancel = v.ic;
    d_req     = v.dr;
    d_we      = v.dw;
    d_addr    = v.da;
    d_wdata   = v.dwd;
    d_be      = v.be;
  endtask

  task automatic checkVector(input string p, input vec_t v);
    checkOutput({p, ".m_en"},      32'(m_en),      32'(v.men));
    checkOutput({p, ".m_we"},      32'(m_we),      32'(v.mwe));
    checkOutput({p, ".m_addr"},    32'(m_addr),    32'(v.ma));
    checkOutput({p, ".m_be"},      32'(m_be),      32'(v.mbe));
    checkOutput({p, ".m_wdata"},   m_wdata,        v.mwd);
    checkOutput({p, ".if_valid"},  32'(if_valid),  32'(v.ifv));
    checkOutput({p, ".if_rdata"},  if_rdata,       v.ird);
    checkOutput({p, ".d_valid"},   32'(d_valid),   32'(v.dv));
    checkOutput({p, ".d_rdata"},   d_rdata,        v.drd);
    checkOutput({p, ".stall_if"},  32'(stall_if),  32'(v.sif));
    checkOutput({p, ".stall_mem"}, 32'(stall_mem), 32'(v.smem));
  endtask

  task automatic checkAllZero(input string p);
    checkOutput({p, ".m_en"},      32'(m_en),      32'h0);
    checkOutput({p, ".m_we"},      32'(m_we),      32'h0);
    checkOutput({p, ".m_addr"},    32'(m_addr),    32'h0);
    checkOutput({p, ".m_be"},      32'(m_be),      32'h0);
    checkOutput({p, ".m_wdata"},   m_wdata,        32'h0);
    checkOutput({p, ".if_valid"},  32'(if_valid),  32'h0);
    checkOutput({p, ".if_rdata"},  if_rdata,       32'h0);
    checkOutput({p, ".d_valid"},   32'(d_valid),   32'h0);
    checkOutput({p, ".d_rdata"},   d_rdata,        32'h0);
    checkOutput({p, ".stall_if"},  32'(stall_if),  32'h0);
    checkOutput({p, ".stall_mem"}, 32'(stall_mem), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA5000000 + 32'(i);
    mem[9'h004] = D1;
    mem[9'h010] = I1;

    // Lone fetch, MEM_LAT=2
    vecs[0]  = '{1'b1,9'h010,'0,'0,'0,'0,'0,'0, 1'b1,'0,9'h010,4'hF,'0, '0,'0,'0,'0, 1'b1,'0};
    vecs[1]  = '{1'b1,9'h010,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0,'0,'0, 1'b1,'0};
    vecs[2]  = '{1'b1,9'h010,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, 1'b1,I1,'0,'0, '0,'0};
    vecs[3]  = '{'0,'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I1,'0,'0, '0,'0};
    // Contention: data load wins, fetch follows
    vecs[4]  = '{1'b1,9'h020,'0,1'b1,'0,9'h004,'0,4'hF, 1'b1,'0,9'h004,4'hF,'0, '0,I1,'0,'0, 1'b1,1'b1};
    vecs[5]  = '{1'b1,9'h020,'0,1'b1,'0,9'h004,'0,4'hF, '0,'0,'0,'0,'0, '0,I1,'0,'0, 1'b1,1'b1};
    vecs[6]  = '{1'b1,9'h020,'0,1'b1,'0,9'h004,'0,4'hF, '0,'0,'0,'0,'0, '0,I1,1'b1,D1, 1'b1,'0};
    vecs[7]  = '{1'b1,9'h020,'0,'0,'0,'0,'0,'0, 1'b1,'0,9'h020,4'hF,'0, '0,I1,'0,D1, 1'b1,'0};
    vecs[8]  = '{1'b1,9'h020,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I1,'0,D1, 1'b1,'0};
    vecs[9]  = '{1'b1,9'h020,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, 1'b1,I2,'0,D1, '0,'0};
    // Store burst
    vecs[10] = '{'0,'0,'0,1'b1,1'b1,9'h100,32'hDEADBEEF,4'b0011, 1'b1,1'b1,9'h100,4'b0011,32'hDEADBEEF, '0,I2,1'b1,D1, '0,'0};
    vecs[11] = vecs[10];
    vecs[12] = vecs[10];
    vecs[13] = '{'0,'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I2,'0,D1, '0,'0};
    // Cancel during an in-flight fetch, then new fetch
    vecs[14] = '{1'b1,9'h030,'0,'0,'0,'0,'0,'0, 1'b1,'0,9'h030,4'hF,'0, '0,I2,'0,D1, 1'b1,'0};
    vecs[15] = '{1'b1,9'h030,1'b1,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I2,'0,D1, '0,'0};
    vecs[16] = '{1'b1,9'h040,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I2,'0,D1, 1'b1,'0};
    vecs[17] = '{1'b1,9'h040,'0,'0,'0,'0,'0,'0, 1'b1,'0,9'h040,4'hF,'0, '0,I2,'0,D1, 1'b1,'0};
    vecs[18] = '{1'b1,9'h040,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I2,'0,D1, 1'b1,'0};
    vecs[19] = '{1'b1,9'h040,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, 1'b1,I3,'0,D1, '0,'0};
    vecs[20] = '{'0,'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I3,'0,D1, '0,'0};
    // Cancelled fetch in IDLE is not eligible
    vecs[21] = '{1'b1,9'h060,1'b1,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I3,'0,D1, '0,'0};
    vecs[22] = '{'0,'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I3,'0,D1, '0,'0};
    // Data request arriving while a fetch is in flight
    vecs[23] = '{1'b1,9'h070,'0,'0,'0,'0,'0,'0, 1'b1,'0,9'h070,4'hF,'0, '0,I3,'0,D1, 1'b1,'0};
    vecs[24] = '{1'b1,9'h070,'0,1'b1,'0,9'h004,'0,4'hF, '0,'0,'0,'0,'0, '0,I3,'0,D1, 1'b1,1'b1};
    vecs[25] = '{1'b1,9'h070,'0,1'b1,'0,9'h004,'0,4'hF, '0,'0,'0,'0,'0, 1'b1,I4,'0,D1, '0,1'b1};
    vecs[26] = '{'0,'0,'0,1'b1,'0,9'h004,'0,4'hF, 1'b1,'0,9'h004,4'hF,'0, '0,I4,'0,D1, '0,1'b1};
    vecs[27] = '{'0,'0,'0,1'b1,'0,9'h004,'0,4'hF, '0,'0,'0,'0,'0, '0,I4,'0,D1, '0,1'b1};
    vecs[28] = '{'0,'0,'0,1'b1,'0,9'h004,'0,4'hF, '0,'0,'0,'0,'0, '0,I4,1'b1,D1, '0,'0};
    vecs[29] = '{'0,'0,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,I4,'0,D1, '0,'0};

    // Reset state, with requests already asserted
    rst_n = 1'b0;
    applyStimulus('{1'b1,9'h010,'0,1'b1,1'b1,9'h100,32'h1,4'hF, '0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0});
    #12;
    checkAllZero("reset");
    applyStimulus(vecs[29]);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[n]);
      @(negedge clk);
      checkVector($sformatf("v%0d", n), vecs[n]);
    end

    // Continuous stores with a waiting fetch
    for (int t = 0; t < 7; t++) begin
      @(posedge clk);
      #1;
      applyStimulus('{1'b1,9'h050,'0,1'b1,1'b1,9'h180,32'h1,4'hF, '0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0});
      @(negedge clk);
`ifdef ARB_STARVE_GUARD_EN
      checkOutput($sformatf("starve%0d.m_en", t), 32'(m_en), 32'((t != 3) && (t != 4)));
      checkOutput($sformatf("starve%0d.m_we", t), 32'(m_we), 32'((t < 2) || (t > 4)));
      checkOutput($sformatf("starve%0d.m_addr", t), 32'(m_addr),
                  (t < 2 || t > 4) ? 32'h180 : ((t == 2) ? 32'h050 : 32'h0));
      checkOutput($sformatf("starve%0d.if_valid", t), 32'(if_valid), 32'(t == 4));
      if (t == 4) checkOutput("starve4.if_rdata", if_rdata, 32'hA5000050);
`else
      checkOutput($sformatf("strict%0d.m_we", t), 32'(m_we), 32'h1);
      checkOutput($sformatf("strict%0d.m_addr", t), 32'(m_addr), 32'h180);
      checkOutput($sformatf("strict%0d.if_valid", t), 32'(if_valid), 32'h0);
`endif
    end
    @(posedge clk);
    #1;
    applyStimulus(vecs[29]);

    // Reset asserted in the middle of a load
    @(posedge clk);
    #1;
    applyStimulus(vecs[26]);
    @(negedge clk);
    checkOutput("rstmid.issue", 32'(m_en), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("rstmid");
    @(negedge clk);
    applyStimulus(vecs[29]);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid.post%0d.d_valid", t), 32'(d_valid), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported unified instruction/data memory shared by the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline. Grants one access at a time and tracks the fixed read latency. Drives per-stage stall signals so the pipeline register for the losing or waiting stage holds. Cancels in-flight fetches on redirect.

## Interface
- `ADDR_W`, 9: word address width, matching the PC width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: cycles from read issue to valid `m_rdata`; legal range 1..7.
- `STARVE_MAX`, 4: maximum consecutive data grants while a fetch waits; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_valid` or `if_cancel`.
- `if_addr` in ADDR_W: fetch address.
- `if_cancel` in 1: branch/jump redirect; kills the pending or in-flight fetch.
- `if_rdata` out DATA_W: fetched instruction.
- `if_valid` out 1: one-cycle pulse; `if_rdata` is valid.
- `d_req` in 1: data request from the MEM stage; held with its fields until `d_valid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_be` in 4: store byte enables.
- `d_rdata` out DATA_W: load data.
- `d_valid` out 1: one-cycle pulse; store done or load data valid.
- `stall_if` out 1: hold IF/ID.
- `stall_mem` out 1: hold EX/MEM and upstream.
- `m_en`, `m_we` out 1: memory access strobe and write enable.
- `m_addr` out ADDR_W, `m_wdata` out DATA_W, `m_be` out 4: memory command fields.
- `m_rdata` in DATA_W: memory read data, valid `MEM_LAT` cycles after a read issue.

## Operation
- **States:** IDLE, RD_IF, RD_D. There is a 3-bit latency counter `lat`, a cancel flag `kill`, and a 4-bit starvation counter `starve`.
- **IDLE arbitration.** Data has priority over fetch. A fetch with `if_cancel`=1 in the same cycle is not eligible.
  - Data store granted: combinational `m_en`=`m_we`=1 with the `d_*` fields. `d_valid`=1 in the same cycle. State stays IDLE.
  - Data load granted: `m_en`=1, `m_we`=0. Go to RD_D with `lat`=MEM_LAT-1.
  - Fetch granted: `m_en`=1, `m_we`=0, `m_be`=4'hF, `m_addr`=`if_addr`. Go to RD_IF with `lat`=MEM_LAT-1.
- **RD_*.** `m_en`=0. `lat` decrements each cycle. When `lat`=0, the read is complete: `m_rdata` is routed to `if_rdata`/`d_rdata` and the matching valid pulses, and the next state is IDLE.
- **Cancel.** `if_cancel` while in RD_IF sets `kill`. At completion, `if_valid` is suppressed if `kill` or `if_cancel` is 1. `kill` clears on return to IDLE. The memory read is never aborted.
- **Stalls (combinational).**
  - `stall_if` = `if_req` & ~`if_valid` & ~`if_cancel`.
  - `stall_mem` = `d_req` & ~`d_valid`.
- **Idle outputs.** Data outputs hold their last value. `m_*` fields are 0 when `m_en`=0.

## Timing
- **Reset:** all outputs 0; state IDLE; `lat`, `kill`, `starve` = 0. Asserting reset mid-read discards the read and no valid is produced.
- **Read latency:** issue at cycle T, valid at T+MEM_LAT, next issue no earlier than T+MEM_LAT+1.
- **Store:** completes in a single cycle. Back-to-back stores are granted every cycle.
- **Simultaneous `if_req` and `d_req` in IDLE:** data wins (subject to the starvation guard).
- **`d_req` rising during RD_IF:** waits for IDLE. `stall_mem`=1 throughout the wait.

## Configuration
- **`ARB_STARVE_GUARD_EN` defined:**
  - `starve` increments on each data grant made while `if_req`=1.
  - `starve` clears on a fetch grant or when `if_req`=0.
  - When `starve`=STARVE_MAX, the next IDLE arbitration grants an eligible fetch over `d_req`.
- **Undefined:** strict data priority. The `starve` logic is absent.

## Test plan
- **Lone fetch.** MEM_LAT=2; `if_req` with `if_addr`=9'h010 at T0; memory returns 32'h00500093.
  - Required: `m_en` only at T0; `if_valid`=1 with 32'h00500093 at T2; `stall_if`=1 at T0–T1.
- **Contention.** `if_req` and a `d_req` load to 9'h004 both at T0.
  - Required: data issued at T0, `d_valid` at T2; fetch issued at T3, `if_valid` at T5.
- **Store burst.** `d_req`/`d_we` held for 3 cycles, `d_be`=4'b0011.
  - Required: `m_we`=1 and `d_valid`=1 in each of the 3 cycles; `stall_mem`=0 throughout.
- **Cancel.** Fetch issued at T0; `if_cancel` at T1.
  - Required: no `if_valid` at T2; state IDLE at T3; a new fetch is issued at T3.
- **Starvation.** `ARB_STARVE_GUARD_EN` defined, STARVE_MAX=2; continuous `d_req` stores and `if_req` from T0.
  - Required: stores at T0 and T1, fetch issued at T2, then stores resume.
  - With the macro undefined: no fetch is issued while `d_req`=1.
- **Reset mid-read.** `rst_n` low at T1 of a load.
  - Required: all outputs 0 immediately; no `d_valid` after release.
